// File: rtl/xenos_wdg_ctrl.sv
// xenos_wdg_ctrl: windowed watchdog and fault-signalling front end for the
// XENOS state machine. Host kicks are timed against a [WINDOW_MIN, TIMEOUT)
// window. An expiry produces a one-cycle wdg_trigger pulse. Repeated misses,
// an early kick or an external fault event produce a held fault_input level
// that lasts FAULT_HOLD cycles.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   kick         host watchdog kick (single-cycle pulse)
//   fault_event  external fault pulse
//   err_clr      clears the sticky early_err flag
//   fsm_state    XENOS current_state (IDLE/ACTIVE/FAULT/SAFE/BOOT/RECOVER)
//   wdg_reset    XENOS wdg_reset, sampled synchronously
//   wdg_trigger  one-cycle expiry pulse to XENOS (registered)
//   fault_input  held fault level to XENOS (registered)
//   armed        high while the watchdog is armed
//   miss_cnt     consecutive expiry count, saturating at 3
//   wd_count     current watchdog counter
//   early_err    sticky early-kick flag
module xenos_wdg_ctrl #(
    parameter logic [15:0] TIMEOUT    = 16'd500,
    parameter logic [15:0] WINDOW_MIN = 16'd50,
    parameter logic [1:0]  MAX_MISSES = 2'd2,
    parameter logic [7:0]  FAULT_HOLD = 8'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kick,
    input  logic        fault_event,
    input  logic        err_clr,
    input  logic [2:0]  fsm_state,
    input  logic        wdg_reset,
    output logic        wdg_trigger,
    output logic        fault_input,
    output logic        armed,
    output logic [1:0]  miss_cnt,
    output logic [15:0] wd_count,
    output logic        early_err
);

    localparam logic [2:0] XS_IDLE    = 3'b000;
    localparam logic [2:0] XS_ACTIVE  = 3'b001;
    localparam logic [2:0] XS_SAFE    = 3'b011;
    localparam logic [2:0] XS_BOOT    = 3'b100;
    localparam logic [2:0] XS_RECOVER = 3'b101;

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_EXPIRED  = 2'd2,
        S_FAULTING = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] hold_cnt;

    // Qualifiers for the ARMED priority chain
    logic paused_c;
    logic abort_c;
    logic arm_ok_c;
    logic at_limit_c;
    logic kick_early_c;
    logic set_early_c;

    assign paused_c     = (fsm_state == XS_SAFE) || (fsm_state == XS_RECOVER);
    assign abort_c      = (fsm_state == XS_BOOT) || wdg_reset;
    assign arm_ok_c     = ((fsm_state == XS_IDLE) || (fsm_state == XS_ACTIVE)) && !wdg_reset;
    assign at_limit_c   = (wd_count == (TIMEOUT - 16'd1));
    assign kick_early_c = kick && (wd_count < WINDOW_MIN);
    assign set_early_c  = (state == S_ARMED) && !abort_c && !fault_event
                          && !paused_c && kick_early_c;

    // Watchdog FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_DISARMED;
            hold_cnt    <= 8'd0;
            wdg_trigger <= 1'b0;
            fault_input <= 1'b0;
            armed       <= 1'b0;
            miss_cnt    <= 2'd0;
            wd_count    <= 16'd0;
            early_err   <= 1'b0;
        end else begin
            // Sticky flag: a new early kick wins over a simultaneous clear
            if (set_early_c) begin
                early_err <= 1'b1;
            end else if (err_clr) begin
                early_err <= 1'b0;
            end

            case (state)
                S_DISARMED: begin
                    wd_count <= 16'd0;
                    hold_cnt <= 8'd0;
                    if (arm_ok_c) begin
                        state <= S_ARMED;
                        armed <= 1'b1;
                    end
                end

                S_ARMED: begin
                    if (abort_c) begin
                        state    <= S_DISARMED;
                        armed    <= 1'b0;
                        wd_count <= 16'd0;
                        miss_cnt <= 2'd0;
                    end else if (fault_event || (!paused_c && kick_early_c)) begin
                        state       <= S_FAULTING;
                        armed       <= 1'b0;
                        fault_input <= 1'b1;
                        hold_cnt    <= 8'd0;
                        wd_count    <= 16'd0;
                    end else if (paused_c) begin
                        // Counter frozen, kicks ignored
                        wd_count <= wd_count;
                    end else if (kick) begin
                        // Valid kick beats a same-cycle expiry
                        wd_count <= 16'd0;
                        miss_cnt <= 2'd0;
                    end else if (at_limit_c) begin
                        state       <= S_EXPIRED;
                        armed       <= 1'b0;
                        wdg_trigger <= 1'b1;
                        wd_count    <= 16'd0;
                        miss_cnt    <= (miss_cnt == 2'd3) ? miss_cnt : miss_cnt + 2'd1;
                    end else begin
                        wd_count <= wd_count + 16'd1;
                    end
                end

                S_EXPIRED: begin
                    // Single-cycle state; wdg_reset and other inputs ignored
                    wdg_trigger <= 1'b0;
                    wd_count    <= 16'd0;
                    if (miss_cnt == MAX_MISSES) begin
                        state       <= S_FAULTING;
                        fault_input <= 1'b1;
                        hold_cnt    <= 8'd0;
                    end else begin
                        state <= S_ARMED;
                        armed <= 1'b1;
                    end
                end

                S_FAULTING: begin
                    // Hold runs to completion regardless of inputs
                    if (hold_cnt == (FAULT_HOLD - 8'd1)) begin
                        state       <= S_DISARMED;
                        fault_input <= 1'b0;
                        miss_cnt    <= 2'd0;
                        hold_cnt    <= 8'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                default: begin
                    state       <= S_DISARMED;
                    wdg_trigger <= 1'b0;
                    fault_input <= 1'b0;
                    armed       <= 1'b0;
                    wd_count    <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xenos_wdg_ctrl.sv
// tb_xenos_wdg_ctrl: directed scoreboard bench for xenos_wdg_ctrl.
// Stimulus pushes the expected wdg_trigger pulses and fault_input holds
// (cycle, miss count or hold length) into a queue; a negedge monitor pops
// and compares whenever the DUT shows one of those outputs.
module tb_xenos_wdg_ctrl;

    localparam logic [2:0] XS_IDLE   = 3'b000;
    localparam logic [2:0] XS_ACTIVE = 3'b001;
    localparam logic [2:0] XS_SAFE   = 3'b011;
    localparam logic [2:0] XS_BOOT   = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kick = 1'b0;
    logic        fault_event = 1'b0;
    logic        err_clr = 1'b0;
    logic [2:0]  fsm_state = XS_IDLE;
    logic        wdg_reset = 1'b0;
    logic        wdg_trigger;
    logic        fault_input;
    logic        armed;
    logic [1:0]  miss_cnt;
    logic [15:0] wd_count;
    logic        early_err;

    xenos_wdg_ctrl #(
        .TIMEOUT    (16'd20),
        .WINDOW_MIN (16'd5),
        .MAX_MISSES (2'd2),
        .FAULT_HOLD (8'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kick        (kick),
        .fault_event (fault_event),
        .err_clr     (err_clr),
        .fsm_state   (fsm_state),
        .wdg_reset   (wdg_reset),
        .wdg_trigger (wdg_trigger),
        .fault_input (fault_input),
        .armed       (armed),
        .miss_cnt    (miss_cnt),
        .wd_count    (wd_count),
        .early_err   (early_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit is_fault;
        int at;
        int val;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit f, input int at, input int v);
        exp_t e;
        e.is_fault = f;
        e.at       = at;
        e.val      = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Abort through wdg_reset, then re-arm; returns the cycle armed rises
    task automatic rearm(output int a);
        wdg_reset = 1'b1;
        tick();
        chk("abort_disarmed", armed, 0);
        chk("abort_wd_count", wd_count, 0);
        wdg_reset = 1'b0;
        tick();
        chk("rearm_armed", armed, 1);
        chk("rearm_miss_cnt", miss_cnt, 0);
        a = cyc;
    endtask

    // Monitor: compares every trigger pulse and every completed fault hold
    bit   prev_trig  = 1'b0;
    bit   prev_fault = 1'b0;
    int   rise_at    = 0;
    int   flen       = 0;
    exp_t me;

    always @(negedge clk) begin
        if (wdg_trigger === 1'b1) begin
            chk("trig_not_back_to_back", 32'(prev_trig), 0);
            chk("trig_fault_exclusive", 32'(fault_input), 0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_trigger: got pulse at cycle %0d expected none", cyc);
            end else begin
                me = sb.pop_front();
                chk("trig_kind", 32'(me.is_fault), 0);
                chk("trig_cycle", cyc, me.at);
                chk("trig_miss_cnt", 32'(miss_cnt), me.val);
            end
        end
        if (fault_input === 1'b1) begin
            if (!prev_fault) rise_at = cyc;
            flen++;
        end else if (prev_fault) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_fault: got hold at cycle %0d expected none", rise_at);
            end else begin
                me = sb.pop_front();
                chk("fault_kind", 32'(me.is_fault), 1);
                chk("fault_start", rise_at, me.at);
                chk("fault_len", flen, me.val);
            end
            flen = 0;
        end
        prev_trig  = (wdg_trigger === 1'b1);
        prev_fault = (fault_input === 1'b1);
    end

    initial begin
        int a;
        int b;
        int c;
        int d;

        // Reset state
        tick();
        tick();
        tick();
        chk("reset_outputs", {wdg_trigger, fault_input, armed, miss_cnt, wd_count, early_err}, 0);

        // Arm and expire: armed at a, trigger at a+20 with miss_cnt=1
        a = cyc + 1;
        push(0, a + 20, 1);
        rst_n = 1'b1;
        wait_until(a);
        chk("armed_rise", armed, 1);
        chk("wd_at_arm", wd_count, 0);
        wait_until(a + 10);
        chk("wd_counting", wd_count, 10);
        wait_until(a + 21);
        chk("rearmed_after_expiry", armed, 1);
        chk("wd_restart", wd_count, 0);
        chk("miss_after_expiry", miss_cnt, 1);
        wait_until(a + 22);
        rearm(a);

        // Valid kicks every 11 cycles at wd_count=10
        b = a;
        for (int k = 0; k < 18; k++) begin
            wait_until(b + 10);
            kick = 1'b1;
            tick();
            kick = 1'b0;
            b = cyc;
        end
        chk("kicks_miss_cnt", miss_cnt, 0);
        chk("kicks_wd_cleared", wd_count, 0);
        wait_until(b + 19);
        chk("wd_at_limit", wd_count, 19);
        kick = 1'b1;
        tick();
        kick = 1'b0;
        chk("limit_kick_wd", wd_count, 0);
        chk("limit_kick_armed", armed, 1);
        rearm(a);

        // Escalation: two expiries then a 4-cycle hold
        push(0, a + 20, 1);
        push(0, a + 41, 2);
        push(1, a + 42, 4);
        wait_until(a + 46);
        chk("esc_disarmed", armed, 0);
        chk("esc_miss_cleared", miss_cnt, 0);
        wait_until(a + 47);
        chk("esc_rearmed", armed, 1);
        a = a + 47;

        // Early kick at wd_count=3
        wait_until(a + 3);
        push(1, a + 4, 4);
        kick = 1'b1;
        tick();
        kick = 1'b0;
        chk("early_err_set", early_err, 1);
        wait_until(a + 9);
        chk("early_rearmed", armed, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("early_err_cleared", early_err, 0);
        a = a + 9;
        wait_until(a + 3);
        push(1, a + 4, 4);
        kick    = 1'b1;
        err_clr = 1'b1;
        tick();
        kick    = 1'b0;
        err_clr = 1'b0;
        chk("early_set_beats_clr", early_err, 1);
        wait_until(a + 9);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        b = a + 9;

        // Pause: SAFE for 7 edges at wd_count=8, ignored kick inside
        push(0, b + 27, 1);
        wait_until(b + 8);
        fsm_state = XS_SAFE;
        wait_until(b + 10);
        kick = 1'b1;
        tick();
        kick = 1'b0;
        wait_until(b + 15);
        chk("pause_wd_held", wd_count, 8);
        chk("pause_still_armed", armed, 1);
        fsm_state = XS_IDLE;
        wait_until(b + 28);
        chk("pause_rearm_wd", wd_count, 0);
        wait_until(b + 40);
        chk("abort_wd_before", wd_count, 12);
        wdg_reset = 1'b1;
        tick();
        chk("abort_armed", armed, 0);
        chk("abort_wd", wd_count, 0);
        chk("abort_miss", miss_cnt, 0);
        wdg_reset = 1'b0;
        tick();
        c = cyc;
        chk("abort_rearmed", armed, 1);

        // wdg_reset and kick during FAULTING do not shorten the hold
        wait_until(c + 2);
        push(1, c + 3, 4);
        fault_event = 1'b1;
        tick();
        fault_event = 1'b0;
        chk("fault_event_hold", fault_input, 1);
        wait_until(c + 4);
        wdg_reset = 1'b1;
        kick      = 1'b1;
        tick();
        kick = 1'b0;
        tick();
        wdg_reset = 1'b0;
        wait_until(c + 7);
        chk("fault_done_low", fault_input, 0);
        wait_until(c + 8);
        chk("fault_done_rearm", armed, 1);
        d = c + 8;

        // Reset in the 2nd FAULTING cycle
        wait_until(d + 1);
        push(1, d + 2, 1);
        fault_event = 1'b1;
        tick();
        fault_event = 1'b0;
        wait_until(d + 3);
        rst_n = 1'b0;
        #1;
        chk("midfault_reset_outputs", {wdg_trigger, fault_input, armed, miss_cnt, wd_count, early_err}, 0);
        tick();
        fsm_state = XS_BOOT;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_reset_disarmed", {wdg_trigger, fault_input, armed, miss_cnt, wd_count, early_err}, 0);
        fsm_state = XS_ACTIVE;
        tick();
        chk("post_reset_arm_active", armed, 1);

        tick();
        tick();
        tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
